// File: rtl/motor_pio_edge_in_if.sv
// Avalon-MM slave bus bundle for motor_pio_edge_in.
// Word-addressed, 32-bit data, single-cycle writes.
interface motor_pio_edge_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/motor_pio_edge_in.sv
// Edge-capturing PIO input with maskable level IRQ.
// Define MOTOR_PIO_DEBOUNCE_EN to add a per-bit debounce filter.
module motor_pio_edge_in #(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    motor_pio_edge_in_if.slave bus,
    input  logic [WIDTH-1:0]   in_port,
    output logic               irq
);

    if (WIDTH < 1 || WIDTH > 32 ||
        EDGE_TYPE < 0 || EDGE_TYPE > 2 ||
        DEBOUNCE_CYCLES < 2 ||
        DEBOUNCE_CYCLES > 65535) begin : g_bad_cfg
        $error("motor_pio_edge_in: illegal parameter");
    end

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_d;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] wdat;
    logic             irq_q;
    logic [31:0]      rdata_q;
    logic [31:0]      rdata_d;
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wdat         = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

`ifdef MOTOR_PIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] filt_q;
    logic [WIDTH-1:0] filt_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // Counter tracks consecutive cycles sync differs from the filtered bit.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync2_q;
`endif

    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = filt & ~hist_q;
            1:       edge_det = ~filt & hist_q;
            default: edge_det = filt ^ hist_q;
        endcase
    end

    // Edge is OR'd in after the clear so a coincident set wins.
    always_comb begin
        mask_d = mask_q;
        clr    = '0;
        if (wr_en && bus.address == 2'd1) begin
            mask_d = wdat;
        end
        if (wr_en && bus.address == 2'd3) begin
            clr = wdat;
        end
        cap_d = (cap_q & ~clr) | edge_det;
    end

    always_comb begin
        rdata_d = '0;
        unique case (bus.address)
            2'd0:    rdata_d[WIDTH-1:0] = filt;
            2'd1:    rdata_d[WIDTH-1:0] = mask_q;
            2'd3:    rdata_d[WIDTH-1:0] = cap_q;
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q  <= '0;
            mask_q  <= '0;
            cap_q   <= '0;
            irq_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            hist_q  <= filt;
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            irq_q   <= |(cap_q & mask_q);
            rdata_q <= rdata_d;
        end
    end

    assign irq          = irq_q;
    assign bus.readdata = rdata_q;

endmodule

// File: tb/tb_motor_pio_edge_in.sv
// Bench for motor_pio_edge_in: rising-edge and any-edge instances
// side by side, checked against a pin-history reference model.
module tb_motor_pio_edge_in;

    localparam int DB = 16;
`ifdef MOTOR_PIO_DEBOUNCE_EN
    localparam int DLY = DB + 2;
`else
    localparam int DLY = 2;
`endif
    localparam int SETTLE = DLY + 8;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b1;
    logic [1:0]  address    = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = 32'h0;
    logic [3:0]  in_port    = 4'h0;
    logic        irq0;
    logic        irq1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    motor_pio_edge_in_if b0 ();
    motor_pio_edge_in_if b1 ();

    assign b0.address    = address;
    assign b0.chipselect = chipselect;
    assign b0.write_n    = write_n;
    assign b0.writedata  = writedata;
    assign b1.address    = address;
    assign b1.chipselect = chipselect;
    assign b1.write_n    = write_n;
    assign b1.writedata  = writedata;

    motor_pio_edge_in #(
        .WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(DB)
    ) u_rise (
        .clk(clk), .reset_n(reset_n), .bus(b0),
        .in_port(in_port), .irq(irq0)
    );

    motor_pio_edge_in #(
        .WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DB)
    ) u_any (
        .clk(clk), .reset_n(reset_n), .bus(b1),
        .in_port(in_port), .irq(irq1)
    );

    logic [31:0] rd [2];
    logic        irqv [2];
    assign rd[0]   = b0.readdata;
    assign rd[1]   = b1.readdata;
    assign irqv[0] = irq0;
    assign irqv[1] = irq1;

    // Reference model: pins seen one/two edges ago, filtered view now
    // and one edge earlier, and the register file per instance.
    logic [3:0]  pp1_m, pp2_m, fl_m, fl_old_m;
    logic [3:0]  cap_m [2];
    logic [3:0]  mask_m [2];
    logic        irq_m [2];
    logic [31:0] rd_m [2];
    int          run_m [4];

    wire       wr_now  = chipselect & ~write_n;
    wire [3:0] clr_now = (wr_now && address == 2'd3) ? writedata[3:0] : 4'h0;
    wire       mwr_now = wr_now && address == 2'd1;

    function automatic logic [3:0] edges(logic [3:0] now, logic [3:0] was, int et);
        case (et)
            0:       return now & ~was;
            1:       return ~now & was;
            default: return now ^ was;
        endcase
    endfunction

    function automatic logic [31:0] regval(logic [1:0] a, logic [3:0] d,
                                           logic [3:0] m, logic [3:0] c);
        case (a)
            2'd0:    return {28'h0, d};
            2'd1:    return {28'h0, m};
            2'd3:    return {28'h0, c};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pp1_m    <= 4'h0;
            pp2_m    <= 4'h0;
            fl_m     <= 4'h0;
            fl_old_m <= 4'h0;
            for (int k = 0; k < 2; k++) begin
                cap_m[k]  <= 4'h0;
                mask_m[k] <= 4'h0;
                irq_m[k]  <= 1'b0;
                rd_m[k]   <= 32'h0;
            end
            for (int b = 0; b < 4; b++) run_m[b] <= 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                cap_m[k]  <= (cap_m[k] & ~clr_now) |
                             edges(fl_m, fl_old_m, (k == 0) ? 0 : 2);
                mask_m[k] <= mwr_now ? writedata[3:0] : mask_m[k];
                irq_m[k]  <= |(cap_m[k] & mask_m[k]);
                rd_m[k]   <= regval(address, fl_m, mask_m[k], cap_m[k]);
            end
            fl_old_m <= fl_m;
            pp2_m    <= pp1_m;
            pp1_m    <= in_port;
`ifdef MOTOR_PIO_DEBOUNCE_EN
            for (int b = 0; b < 4; b++) begin
                if (pp2_m[b] == fl_m[b]) begin
                    run_m[b] <= 0;
                end else if (run_m[b] + 1 >= DB) begin
                    fl_m[b]  <= pp2_m[b];
                    run_m[b] <= 0;
                end else begin
                    run_m[b] <= run_m[b] + 1;
                end
            end
`else
            fl_m <= pp1_m;
`endif
        end
    end

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = $urandom;
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (rd[k] !== 32'h0 || irqv[k] !== 1'b0) begin
                    bad++;
                    $display("FAIL reset dut%0d rd=%h irq=%b want 0/0", k, rd[k], irqv[k]);
                end
            end
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (rd[k] !== rd_m[k] || irqv[k] !== irq_m[k]) begin
                    bad++;
                    $display("FAIL post_reset dut%0d rd=%h irq=%b want %h/%b",
                             k, rd[k], irqv[k], rd_m[k], irq_m[k]);
                end
            end
        end
    endtask

    task automatic test_data_read();
        in_port = 4'hA;
        address = 2'd0;
        repeat (SETTLE) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (rd[k] !== rd_m[k] || irqv[k] !== irq_m[k]) begin
                    bad++;
                    $display("FAIL data dut%0d rd=%h irq=%b want %h/%b",
                             k, rd[k], irqv[k], rd_m[k], irq_m[k]);
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (rd[k] !== 32'hA) begin
                bad++;
                $display("FAIL data_A dut%0d rd=%h want 0000000a", k, rd[k]);
            end
        end
        address = 2'd2;
        repeat (4) begin
            in_port = 4'($urandom_range(0, 15));
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (rd[k] !== 32'h0) begin
                    bad++;
                    $display("FAIL reserved dut%0d rd=%h want 0", k, rd[k]);
                end
            end
        end
    endtask

    task automatic test_edge_clear();
        in_port = 4'h0;
        address = 2'd3;
        repeat (SETTLE) @(negedge clk);
        bus_wr(2'd3, 32'hF);
        bus_wr(2'd1, 32'h1);
        address = 2'd3;
        in_port = 4'h1;
        repeat (SETTLE) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (rd[k] !== rd_m[k] || irqv[k] !== irq_m[k]) begin
                    bad++;
                    $display("FAIL edge dut%0d rd=%h irq=%b want %h/%b",
                             k, rd[k], irqv[k], rd_m[k], irq_m[k]);
                end
            end
        end
        total++;
        if (rd[0] !== 32'h1 || irqv[0] !== 1'b1) begin
            bad++;
            $display("FAIL edge_cap rd=%h irq=%b want 1/1", rd[0], irqv[0]);
        end
        bus_wr(2'd3, 32'h1);
        @(negedge clk);
        total++;
        if (rd[0] !== 32'h0 || irqv[0] !== 1'b0) begin
            bad++;
            $display("FAIL w1c rd=%h irq=%b want 0/0", rd[0], irqv[0]);
        end
    endtask

    task automatic test_set_wins();
        bus_wr(2'd1, 32'h1);
        for (int d = DLY - 2; d <= DLY + 2; d++) begin
            in_port = 4'h0;
            address = 2'd3;
            repeat (SETTLE) @(negedge clk);
            bus_wr(2'd3, 32'hF);
            address = 2'd3;
            in_port = 4'h1;
            repeat (d) begin
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    total++;
                    if (rd[k] !== rd_m[k] || irqv[k] !== irq_m[k]) begin
                        bad++;
                        $display("FAIL pre_clr d=%0d dut%0d rd=%h irq=%b want %h/%b",
                                 d, k, rd[k], irqv[k], rd_m[k], irq_m[k]);
                    end
                end
            end
            bus_wr(2'd3, 32'h1);
            address = 2'd3;
            @(negedge clk);
            if (d == DLY) begin
                total++;
                if (rd[0] !== 32'h1 || irqv[0] !== 1'b1) begin
                    bad++;
                    $display("FAIL set_wins rd=%h irq=%b want 1/1", rd[0], irqv[0]);
                end
            end
            repeat (4) begin
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    total++;
                    if (rd[k] !== rd_m[k] || irqv[k] !== irq_m[k]) begin
                        bad++;
                        $display("FAIL post_clr d=%0d dut%0d rd=%h irq=%b want %h/%b",
                                 d, k, rd[k], irqv[k], rd_m[k], irq_m[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_any_edge_mask();
        bus_wr(2'd1, 32'h0);
        in_port = 4'h0;
        repeat (SETTLE) @(negedge clk);
        bus_wr(2'd3, 32'hF);
        address = 2'd3;
        for (int t = 0; t < 2; t++) begin
            in_port[3] = ~in_port[3];
            repeat (SETTLE) begin
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    total++;
                    if (rd[k] !== rd_m[k] || irqv[k] !== irq_m[k]) begin
                        bad++;
                        $display("FAIL toggle dut%0d rd=%h irq=%b want %h/%b",
                                 k, rd[k], irqv[k], rd_m[k], irq_m[k]);
                    end
                end
            end
        end
        total++;
        if (rd[1] !== 32'h8 || irqv[1] !== 1'b0) begin
            bad++;
            $display("FAIL any_edge rd=%h irq=%b want 8/0", rd[1], irqv[1]);
        end
        bus_wr(2'd1, 32'h8);
        @(negedge clk);
        total++;
        if (irqv[1] !== 1'b1) begin
            bad++;
            $display("FAIL mask_irq irq=%b want 1", irqv[1]);
        end
    endtask

`ifdef MOTOR_PIO_DEBOUNCE_EN
    task automatic test_debounce();
        in_port = 4'h0;
        repeat (SETTLE) @(negedge clk);
        bus_wr(2'd3, 32'hF);
        address = 2'd3;
        for (int p = 0; p < 2; p++) begin
            in_port[2] = 1'b1;
            repeat ((p == 0) ? 10 : 20) @(negedge clk);
            in_port[2] = 1'b0;
            repeat (30) begin
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    total++;
                    if (rd[k] !== rd_m[k] || irqv[k] !== irq_m[k]) begin
                        bad++;
                        $display("FAIL debounce dut%0d rd=%h irq=%b want %h/%b",
                                 k, rd[k], irqv[k], rd_m[k], irq_m[k]);
                    end
                end
            end
            for (int k = 0; k < 2; k++) begin
                total++;
                if (rd[k] !== ((p == 0) ? 32'h0 : 32'h4)) begin
                    bad++;
                    $display("FAIL db_pulse%0d dut%0d rd=%h", p, k, rd[k]);
                end
            end
        end
        bus_wr(2'd3, 32'hF);
        address    = 2'd3;
        in_port[1] = 1'b1;
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        in_port = 4'h0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (rd[k] !== 32'h0 || rd_m[k] !== 32'h0) begin
                bad++;
                $display("FAIL db_abort dut%0d rd=%h model=%h want 0", k, rd[k], rd_m[k]);
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (rd[k] !== rd_m[k] || irqv[k] !== irq_m[k]) begin
                    bad++;
                    $display("FAIL random c=%0d dut%0d rd=%h irq=%b want %h/%b",
                             c, k, rd[k], irqv[k], rd_m[k], irq_m[k]);
                end
            end
            if ($urandom_range(0, 7) == 0) in_port = 4'($urandom_range(0, 15));
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            chipselect = ($urandom_range(0, 3) != 0);
            write_n    = ($urandom_range(0, 5) != 0);
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_async_reset();
        bus_wr(2'd1, 32'h1);
        in_port = 4'h0;
        repeat (SETTLE) @(negedge clk);
        in_port = 4'h1;
        repeat (SETTLE) @(negedge clk);
        total++;
        if (irqv[0] !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset irq=%b want 1", irqv[0]);
        end
        address = 2'd3;
        #2 reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (rd[k] !== 32'h0 || irqv[k] !== 1'b0) begin
                bad++;
                $display("FAIL async_rst dut%0d rd=%h irq=%b want 0/0", k, rd[k], irqv[k]);
            end
        end
        in_port = 4'h0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 1; a <= 3; a += 2) begin
            address = 2'(a);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (rd[k] !== 32'h0 || irqv[k] !== 1'b0) begin
                    bad++;
                    $display("FAIL rst_reg a=%0d dut%0d rd=%h irq=%b want 0/0",
                             a, k, rd[k], irqv[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_data_read();
        test_edge_clear();
        test_set_wins();
        test_any_edge_mask();
`ifdef MOTOR_PIO_DEBOUNCE_EN
        test_debounce();
`endif
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/motor_pio_edge_in.md
MOTOR_PIO_EDGE_IN -- requirements
Module: motor_pio_edge_in

Interface
REQ-001 Parameter WIDTH, default 4: input port width, legal 1..32.
REQ-002 Parameter EDGE_TYPE, default 0: edge sensed; 0 rising, 1 falling, 2 any.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16: stable-cycle count for debounce, legal 2..65535.
REQ-004 Port clk input 1: single clock, all state on rising edge.
REQ-005 Port reset_n input 1: reset, asynchronous, active-low.
REQ-006 Port address input 2: Avalon-MM word address.
REQ-007 Port chipselect input 1: slave select, qualifies writes.
REQ-008 Port write_n input 1: active-low write strobe.
REQ-009 Port writedata input 32: write data.
REQ-010 Port readdata output 32: registered read data.
REQ-011 Port in_port input WIDTH: asynchronous external pins, e.g. motor limit/encoder lines.
REQ-012 Port irq output 1: level interrupt, active-high.

Function
REQ-013 in_port SHALL pass a 2-flop synchronizer; output sync_in is the sole source for data and edge logic.
REQ-014 Register map SHALL be: addr 0 DATA (RO), addr 1 IRQ_MASK (RW, WIDTH bits), addr 2 reserved (reads 0, writes ignored), addr 3 EDGE_CAP (RO, write-1-to-clear).
REQ-015 readdata SHALL update every cycle, whether or not chipselect is asserted, with the addressed register zero-extended to 32 bits; read latency is 1 cycle.
REQ-016 A write SHALL occur only when chipselect=1 and write_n=0; writedata bits above WIDTH are ignored.
REQ-017 Edge detect SHALL compare the filtered input with its 1-cycle-delayed copy, per bit, according to EDGE_TYPE.
REQ-018 A detected edge SHALL set its EDGE_CAP bit on the following clock; the bit holds until cleared.
REQ-019 A write to addr 3 SHALL clear each EDGE_CAP bit whose writedata bit is 1; other bits are unchanged.
REQ-020 If an edge and a clear hit the same bit in the same cycle, set SHALL win and the bit reads 1.
REQ-021 irq SHALL equal OR-reduce(EDGE_CAP & IRQ_MASK), registered, so it lags EDGE_CAP by 1 cycle.
REQ-022 A mask write SHALL take effect on irq 1 cycle after the write cycle; masking does not clear EDGE_CAP.
REQ-023 Repeated edges on an already-set bit SHALL be absorbed with no counting or overflow.

Reset
REQ-024 Assertion of reset_n=0 SHALL asynchronously clear readdata, IRQ_MASK, EDGE_CAP, irq, the synchronizer flops, the edge-history flops and the debounce state to 0.
REQ-025 Deassertion SHALL NOT produce a spurious edge; history is seeded from the reset value 0, so rising edges on pins already high after reset SHALL be captured once.
REQ-026 A reset asserted mid-debounce SHALL abort the count, with no capture.

Configuration
REQ-027 Macro MOTOR_PIO_DEBOUNCE_EN, when defined, SHALL insert a per-bit debounce filter between sync_in and the edge/DATA logic.
REQ-028 The filtered bit SHALL change only after sync_in has differed from it for DEBOUNCE_CYCLES consecutive cycles; any return to the filtered value restarts the counter.
REQ-029 Without the macro, the filtered input SHALL equal sync_in, with no counters synthesized.
REQ-030 With the macro defined, DATA SHALL read the filtered value.

Verification
REQ-031 Reset, then read addr 0 with in_port=4'hA -> readdata=32'hA (2 sync cycles + 1 read cycle); reserved addr 2 reads 0.
REQ-032 EDGE_TYPE=0, mask=4'h1, in_port bit0 0->1 -> EDGE_CAP=4'h1, irq=1; write 4'h1 to addr 3 -> EDGE_CAP=0, irq=0 next cycle.
REQ-033 Clear write of 4'h1 to addr 3 coinciding with a new bit0 edge -> EDGE_CAP bit0 stays 1 and irq stays 1.
REQ-034 EDGE_TYPE=2, mask=0, toggle bit3 twice -> EDGE_CAP=4'h8, irq=0; then write mask 4'h8 -> irq=1 one cycle later.
REQ-035 MOTOR_PIO_DEBOUNCE_EN defined, DEBOUNCE_CYCLES=16: a 10-cycle glitch on bit2 -> no EDGE_CAP change; a 20-cycle high -> bit2 captured exactly once.
REQ-036 Assert reset_n during a pending edge with irq=1 -> irq, EDGE_CAP and IRQ_MASK read 0 immediately, with no clock required.
